fp_mul_norm_round: RTL and testbench

Post-multiply normalise-and-round stage of the floating-point multiplier. It consumes the 48-bit raw mantissa product from the sequential Booth multiplier plus the sign and biased exponent sum prepared upstream, and produces a packed IEEE-754 single-precision result. The stage is a two-stage valid/ready pipeline with full backpressure and a throughput of one result per cycle.

---
 rtl/fp_mul_norm_round.sv | 152 +++++++++++++++
 tb/tb_fp_mul_norm_round.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_norm_round.sv
// Normalise, round and pack a raw 2*MANT_W-bit mantissa product into an IEEE-754 word.
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncate.
module fp_mul_norm_round #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign_in,
  input  logic [EXP_W+1:0]          exp_sum,
  input  logic [2*MANT_W-1:0]       prod,
  input  logic                      zero_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   result,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW   = 2 * MANT_W;
  localparam int unsigned FW   = MANT_W - 1;
  localparam int unsigned XW   = EXP_W + 2;
  localparam int unsigned RW   = EXP_W + MANT_W;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q, s1_sign_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_guard_q, s1_guard_d;
  logic          s1_sticky_q, s1_sticky_d;
  logic [XW-1:0] s1_exp_q, s1_exp_d;
  logic [FW-1:0] s1_mant_q, s1_mant_d;

  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] result_q, result_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          s2_adv_c, s1_adv_c;
  logic          carry_c;
  logic [FW-1:0] mant_r_c;
  logic [XW:0]   exp_r_c;

  assign s2_adv_c = !out_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = s1_adv_c;

  // S1: align the product so the hidden bit drops off the top, keep guard and sticky.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_zero_d   = s1_zero_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_exp_d    = s1_exp_q;
    s1_mant_d   = s1_mant_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = sign_in;
        s1_zero_d = zero_in;
        if (prod[PW-1]) begin
          s1_mant_d   = prod[PW-2 -: FW];
          s1_guard_d  = prod[PW-FW-2];
          s1_sticky_d = |prod[PW-FW-3:0];
          s1_exp_d    = exp_sum + XW'(1);
        end else begin
          s1_mant_d   = prod[PW-3 -: FW];
          s1_guard_d  = prod[PW-FW-3];
          s1_sticky_d = |prod[PW-FW-4:0];
          s1_exp_d    = exp_sum;
        end
      end
    end
  end

`ifdef FP_ROUND_NEAREST_EN
  logic inc_c;
  assign inc_c = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
  assign {carry_c, mant_r_c} = {1'b0, s1_mant_q} + (FW+1)'(inc_c);
`else
  logic unused_round_c;
  assign unused_round_c = s1_guard_q ^ s1_sticky_q;
  assign carry_c        = 1'b0;
  assign mant_r_c       = s1_mant_q;
`endif

  // One extra bit so a rounding carry on the largest exponent cannot wrap the sign.
  assign exp_r_c = {s1_exp_q[XW-1], s1_exp_q} + (XW+1)'(carry_c);

  // S2: classify and pack; holds its outputs while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (s1_zero_q) begin
          result_d = {s1_sign_q, (RW-1)'(0)};
        end else if (!exp_r_c[XW] && (exp_r_c >= (XW+1)'(EMAX))) begin
          result_d   = {s1_sign_q, {EXP_W{1'b1}}, FW'(0)};
          overflow_d = 1'b1;
        end else if (exp_r_c[XW] || (exp_r_c == '0)) begin
          result_d    = {s1_sign_q, (RW-1)'(0)};
          underflow_d = 1'b1;
        end else begin
          result_d = {s1_sign_q, exp_r_c[EXP_W-1:0], mant_r_c};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Bench for fp_mul_norm_round: directed corner beats, backpressure, reset and a random
// stream checked against an arithmetic reference model through an in-order scoreboard.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [9:0]  exp_sum;
  logic [47:0] prod;
  logic        zero_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        uf;
  } exp_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];
  exp_t cur_exp;
  logic acc = 1'b0;

  logic        bs[4];
  int          be[4];
  logic [47:0] bp[4];
  logic        bz[4];

  always #5 clk = ~clk;

  fp_mul_norm_round #(.MANT_W(24), .EXP_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_sum   (exp_sum),
    .prod      (prod),
    .zero_in   (zero_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic ov, input logic uf);
    exp_t e;
    e.res = r;
    e.ov  = ov;
    e.uf  = uf;
    return e;
  endfunction

  // Reference: integer shift, remainder-vs-half rounding, then classification.
  function automatic exp_t model(input logic s, input int e, input logic [47:0] p, input logic z);
    longint unsigned pv, m, rem, half;
    int sh, ee;
    pv   = 64'(p);
    sh   = p[47] ? 24 : 23;
    ee   = e + (p[47] ? 1 : 0);
    m    = pv >> sh;
    rem  = pv & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
`ifdef FP_ROUND_NEAREST_EN
    if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    if (m == (64'd1 << 24)) begin
      m  = 64'd1 << 23;
      ee = ee + 1;
    end
`else
    if (rem > half) m = m + 64'd0;
`endif
    if (z) return mk({s, 31'b0}, 1'b0, 1'b0);
    if (ee >= 255) return mk({s, 8'hFF, 23'b0}, 1'b1, 1'b0);
    if (ee <= 0) return mk({s, 31'b0}, 1'b0, 1'b1);
    return mk({s, 8'(ee), 23'(m)}, 1'b0, 1'b0);
  endfunction

  // One clock: check any output handshake, log any input handshake, advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("overflow", 64'(overflow), 64'(e.ov));
        check("underflow", 64'(underflow), 64'(e.uf));
      end
    end
    acc = in_valid && in_ready;
    if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input int e, input logic [47:0] p, input logic z);
    sign_in  = s;
    exp_sum  = 10'(e);
    prod     = p;
    zero_in  = z;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic s, input int e, input logic [47:0] p, input logic z,
                      input exp_t ex);
    int budget;
    budget = 0;
    drive(s, e, p, z);
    cur_exp = ex;
    do begin
      cycle();
      budget++;
    end while (!acc && budget < 50);
    check("accept_in_time", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget    = 0;
    out_ready = 1'b1;
    while ((sb.size() > 0 || out_valid) && budget < 50) begin
      cycle();
      budget++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic rand_beat(output logic s, output int e, output logic [47:0] p, output logic z);
    logic [63:0] r;
    r = {$urandom, $urandom};
    p = r[47:0];
    if ($urandom % 2 == 0) p[47] = 1'b1;
    else begin
      p[47] = 1'b0;
      p[46] = 1'b1;
    end
    if ($urandom % 4 == 0) p[22:0] = '0;
    if ($urandom % 8 == 0) p[46:23] = '1;
    e = int'($urandom_range(300, 0)) - 20;
    z = ($urandom % 8 == 0);
    s = 1'($urandom % 2);
  endtask

  task automatic present(input int i);
    drive(bs[i], be[i], bp[i], bz[i]);
    cur_exp = model(bs[i], be[i], bp[i], bz[i]);
  endtask

  initial begin
    logic        rs, rz;
    int          re;
    logic [47:0] rp;
    exp_t        hold_exp;

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign_in   = 1'b0;
    exp_sum   = '0;
    prod      = '0;
    zero_in   = 1'b0;
    cur_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    rstn = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: 1.0 x 1.0 appears two edges after it is presented.
    drive(1'b0, 127, 48'h4000_0000_0000, 1'b0);
    #1;
    check("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", 64'(out_valid), 64'd1);
    check("lat_result", 64'(result), 64'h3F80_0000);
    check("lat_flags", 64'({overflow, underflow}), 64'd0);
    @(posedge clk);
    #1;
    check("lat_no_dup", 64'(out_valid), 64'd0);

    // Directed corner beats.
    send(1'b0, 127, 48'h9000_0000_0000, 1'b0, mk(32'h4010_0000, 1'b0, 1'b0));
    send(1'b0, 127, 48'h4000_0040_0000, 1'b0, mk(32'h3F80_0000, 1'b0, 1'b0));
`ifdef FP_ROUND_NEAREST_EN
    send(1'b0, 127, 48'h4000_00C0_0000, 1'b0, mk(32'h3F80_0002, 1'b0, 1'b0));
    send(1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, mk(32'h4000_0000, 1'b0, 1'b0));
`else
    send(1'b0, 127, 48'h4000_00C0_0000, 1'b0, mk(32'h3F80_0001, 1'b0, 1'b0));
    send(1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, mk(32'h3FFF_FFFF, 1'b0, 1'b0));
`endif
    send(1'b1, 254, 48'h8000_0000_0000, 1'b0, mk(32'hFF80_0000, 1'b1, 1'b0));
    send(1'b0, 0,   48'h4000_0000_0000, 1'b0, mk(32'h0000_0000, 1'b0, 1'b1));
    send(1'b1, 300, 48'h4000_0000_0000, 1'b1, mk(32'h8000_0000, 1'b0, 1'b0));
    send(1'b0, 254, 48'h4000_0000_0000, 1'b0, mk(32'h7F00_0000, 1'b0, 1'b0));
    send(1'b0, 1,   48'h4000_0000_0000, 1'b0, mk(32'h0080_0000, 1'b0, 1'b0));
    drain();

    // Backpressure: two beats fill the pipe, the rest wait, output holds.
    for (int i = 0; i < 4; i++) rand_beat(bs[i], be[i], bp[i], bz[i]);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      present(i);
      cycle();
      check("bp_accept", 64'(acc), 64'd1);
    end
    present(2);
    hold_exp = sb[0];
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_stalled", 64'(acc), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'(hold_exp.res));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) present(3);
      if (k >= 2) in_valid = 1'b0;
      check("stream_consecutive", 64'(out_valid), 64'd1);
      cycle();
      if (k < 2) check("stream_accept", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    check("stream_all_out", 64'(sb.size()), 64'd0);
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    rand_beat(rs, re, rp, rz);
    drive(rs, re, rp, rz);
    cur_exp = model(rs, re, rp, rz);
    cycle();
    rand_beat(rs, re, rp, rz);
    drive(rs, re, rp, rz);
    cur_exp = model(rs, re, rp, rz);
    cycle();
    in_valid = 1'b0;
    rstn     = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("midrst_no_stale", 64'(out_valid), 64'd0);
      cycle();
    end
    send(1'b0, 127, 48'h9000_0000_0000, 1'b0, mk(32'h4010_0000, 1'b0, 1'b0));
    drain();

    // Random stream with random backpressure against the model.
    in_valid = 1'b0;
    acc      = 1'b0;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom % 4 != 0);
      if (!in_valid || acc) begin
        if ($urandom % 4 != 0) begin
          rand_beat(rs, re, rp, rz);
          drive(rs, re, rp, rz);
          cur_exp = model(rs, re, rp, rz);
        end else begin
          in_valid = 1'b0;
        end
      end
      cycle();
    end
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
